// File: rtl/hc595_shifter_pkg.sv
// rtl/hc595_shifter_pkg.sv - shared defaults and helpers for the 74HC595 serial output stage
// HC595_DATA_W / HC595_SCLK_DIV may be predefined to keep the scan logic and this stage in agreement.
`ifndef HC595_DATA_W
`define HC595_DATA_W 16
`endif

`ifndef HC595_SCLK_DIV
`define HC595_SCLK_DIV 2
`endif

package hc595_shifter_pkg;

  localparam int DEF_DATA_W   = `HC595_DATA_W;
  localparam int DEF_SCLK_DIV = `HC595_SCLK_DIV;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hc595_shifter.sv
// rtl/hc595_shifter.sv - bit-serial 74HC595 chain driver with phase-locked sh_cp and st_cp latch pulse
// Define HC595_LSB_FIRST_EN to shift bit 0 first (sreg shifts right); default is MSB first.
module hc595_shifter
  import hc595_shifter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              sh_cp,
  output logic              st_cp,
  output logic              ds
);

  localparam int IDX_W = width_min1(DATA_W);
  localparam int CNT_W = width_min1(SCLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic                sh_cp_q, sh_cp_d;
  logic                st_cp_q, st_cp_d;
  logic                ds_q, ds_d;
  logic                tick_last;
  logic                accept;

  assign ready     = (state_q == S_IDLE) && en;
  assign accept    = valid && ready;
  assign tick_last = (cnt_q == CNT_W'(SCLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      sh_cp_q <= 1'b0;
      st_cp_q <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      sh_cp_q <= sh_cp_d;
      st_cp_q <= st_cp_d;
      ds_q    <= ds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LO;
          cnt_d   = '0;
          idx_d   = IDX_W'(DATA_W - 1);
          sreg_d  = data;
        end
      end
      S_LO: begin
        if (tick_last) begin
          cnt_d   = '0;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (tick_last) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_LO;
            idx_d   = idx_q - IDX_W'(1);
`ifdef HC595_LSB_FIRST_EN
            sreg_d  = sreg_q >> 1;
`else
            sreg_d  = sreg_q << 1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (tick_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so they change on the same edge as the FSM.
  always_comb begin
    sh_cp_d = (state_d == S_HI);
    st_cp_d = (state_d == S_LATCH);
    ds_d    = 1'b0;
    if (state_d == S_LO || state_d == S_HI) begin
`ifdef HC595_LSB_FIRST_EN
      ds_d = sreg_d[0];
`else
      ds_d = sreg_d[DATA_W-1];
`endif
    end
  end

  assign sh_cp = sh_cp_q;
  assign st_cp = st_cp_q;
  assign ds    = ds_q;

endmodule

// File: tb/tb_hc595_shifter.sv
// tb/tb_hc595_shifter.sv - self-checking bench for hc595_shifter (default and SCLK_DIV=1 instances)
module tb_hc595_shifter;

  logic        clk = 1'b0;
  logic        reset, en, valid, valid1;
  logic [15:0] data, data1;
  logic        ready, sh_cp, st_cp, ds;
  logic        ready1, sh_cp1, st_cp1, ds1;

  always #5 clk = ~clk;

  hc595_shifter #(.DATA_W(16), .SCLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .data(data), .valid(valid),
    .ready(ready), .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds)
  );

  hc595_shifter #(.DATA_W(16), .SCLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .data(data1), .valid(valid1),
    .ready(ready1), .sh_cp(sh_cp1), .st_cp(st_cp1), .ds(ds1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  int pushed = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: rebuild each word from ds on sh_cp rising edges, compare on st_cp.
  logic [15:0] mon_word = '0;
  int          mon_bits = 0;
  int          lat_pulses = 0;
  int          st_w = 0;
  logic        prev_sh = 1'b0, prev_st = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_bits = 0;
      st_w     = 0;
      prev_sh  = 1'b0;
      prev_st  = 1'b0;
    end else begin
      if (sh_cp && !prev_sh) begin
`ifdef HC595_LSB_FIRST_EN
        mon_word = {ds, mon_word[15:1]};
`else
        mon_word = {mon_word[14:0], ds};
`endif
        mon_bits++;
      end
      if (st_cp) st_w++;
      if (st_cp && !prev_st) begin
        lat_pulses++;
        check("bits_per_word", mon_bits, 16);
        check("latch_queue_size", exp_q.size(), 1);
        if (exp_q.size() != 0) check("word", int'(mon_word), int'(exp_q.pop_front()));
        mon_bits = 0;
      end
      if (!st_cp && prev_st) begin
        check("st_cp_width", st_w, 2);
        st_w = 0;
      end
      prev_sh = sh_cp;
      prev_st = st_cp;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  // Offer a word at the current negedge and count cycles ready stays low.
  task automatic run_word(input logic [15:0] w, input logic keep_valid, output int low);
    data  = w;
    valid = 1'b1;
    exp_q.push_back(w);
    pushed++;
    low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!keep_valid) valid = 1'b0;
      if (ready) break;
      low++;
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        keep_valid;
    int          exp_low;
  } vec_t;

  vec_t vecs[3];
  int   low;
  int   sh_hi, rd_hi, p0, shr, stw;
  logic psh;

  initial begin
    vecs[0] = '{16'hA5C3, 1'b0, 66};
    vecs[1] = '{16'h00FF, 1'b1, 66};
    vecs[2] = '{16'hFF00, 1'b0, 66};

    reset = 1'b1; en = 1'b0; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sh_cp", sh_cp, 0);
    check("rst_st_cp", st_cp, 0);
    check("rst_ds", ds, 0);
    check("rst_ready_en0", ready, 0);
    en = 1'b1;
    #1;
    check("rst_ready_en1", ready, 1);
    @(negedge clk);

    // Table: single word, then a back-to-back pair with valid held high.
    for (int i = 0; i < 3; i++) begin
      wait_ready("vec");
      run_word(vecs[i].word, vecs[i].keep_valid, low);
      check($sformatf("vec%0d_ready_low", i), low, vecs[i].exp_low);
    end
    repeat (4) @(negedge clk);
    check("pulses_after_table", lat_pulses, 3);

    // en low with valid high: nothing accepted.
    en = 1'b0; valid = 1'b1; data = 16'hFFFF;
    sh_hi = 0; rd_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sh_cp) sh_hi++;
      if (ready) rd_hi++;
    end
    check("en0_sh_cp_high_cycles", sh_hi, 0);
    check("en0_ready_high_cycles", rd_hi, 0);
    valid = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // en dropped at cycle 10 of a word: word still completes and latches.
    wait_ready("endrop");
    p0 = lat_pulses;
    data = 16'h5A3C; valid = 1'b1; exp_q.push_back(16'h5A3C); pushed++;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 200 && lat_pulses == p0; i++) @(negedge clk);
    check("endrop_latched", lat_pulses, p0 + 1);
    rd_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) rd_hi++;
    end
    check("endrop_ready_stays_low", rd_hi, 0);
    en = 1'b1;
    #1;
    check("endrop_ready_back", ready, 1);
    @(negedge clk);

    // Reset mid-word: outputs clear, no latch for the aborted word.
    wait_ready("rstmid");
    p0 = lat_pulses;
    data = 16'h1234; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_sh_cp", sh_cp, 0);
    check("rstmid_st_cp", st_cp, 0);
    check("rstmid_ds", ds, 0);
    reset = 1'b0;
    #1;
    check("rstmid_ready", ready, 1);
    repeat (70) @(negedge clk);
    check("rstmid_no_latch", lat_pulses, p0);
    wait_ready("after_rst");
    run_word(16'h8001, 1'b0, low);
    check("w8001_ready_low", low, 66);
    repeat (4) @(negedge clk);
    check("total_pulses", lat_pulses, pushed);
    check("queue_drained", exp_q.size(), 0);

    // SCLK_DIV=1 instance, word FFFF.
    data1 = 16'hFFFF; valid1 = 1'b1;
    low = 0; shr = 0; stw = 0; psh = sh_cp1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      valid1 = 1'b0;
      if (sh_cp1 && !psh) shr++;
      if (st_cp1) stw++;
      psh = sh_cp1;
      if (ready1) break;
      low++;
    end
    check("div1_ready_low", low, 33);
    check("div1_sh_cp_pulses", shr, 16);
    check("div1_st_cp_width", stw, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hc595_shifter.md
# hc595_shifter

Serial output stage for the on-board 74HC595 display chain. It accepts parallel words over a valid/ready handshake and shifts each word out bit-serially on `ds` with a slowed `sh_cp`. It then pulses `st_cp` once to latch the word into the 595 outputs. It sits directly downstream of the display scan logic, which produces one segment/digit-select word per scan step, and drives the top-level `sh_cp`/`st_cp`/`ds` pins.

## Interface
- `DATA_W`, default 16: bits per word, i.e. the chain length; must be ≥ 1.
- `SCLK_DIV`, default 2: `clk` cycles per half-period of `sh_cp` and width of the `st_cp` pulse; must be ≥ 1.
- `clk` input, 1 bit: system clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: enables acceptance of new words.
- `data` input, `DATA_W` bits: word to shift out; sampled only on accept.
- `valid` input, 1 bit: `data` is offered.
- `ready` output, 1 bit: the block can accept a word.
- `sh_cp` output, 1 bit: 595 shift clock.
- `st_cp` output, 1 bit: 595 storage (latch) clock.
- `ds` output, 1 bit: 595 serial data.

## Operation
- The FSM has four states: IDLE, LO, HI, LATCH.
  - A tick counter `cnt` runs 0..`SCLK_DIV`-1.
  - A bit index `idx` is `$clog2(DATA_W)` bits wide, with a minimum of 1.
  - A shift register `sreg` is `DATA_W` bits wide.
- `ready` = (state == IDLE) && `en`. It is combinational from registered state.
- Accept happens when `valid && ready` at a rising edge:
  - `sreg` ← `data`, `idx` ← `DATA_W`-1, `cnt` ← 0, state → LO.
- LO: `sh_cp`=0 and `ds` = current bit (MSB of `sreg` by default). After `SCLK_DIV` cycles, go to HI.
- HI: `sh_cp`=1 and `ds` is held. After `SCLK_DIV` cycles:
  - If `idx`==0, go to LATCH.
  - Otherwise shift `sreg` by one, decrement `idx`, and go to LO.
- LATCH: `sh_cp`=0, `st_cp`=1, `ds`=0. After `SCLK_DIV` cycles: `st_cp`=0 and state → IDLE.
- `valid` while `ready`=0 is ignored; nothing is queued.
- `en` is checked only for acceptance. Deasserting `en` mid-word does not abort: the word completes, including the latch.
- Reset at any point, including mid-word:
  - The next edge forces state IDLE, `sh_cp`=0, `st_cp`=0, `ds`=0, `cnt`=0.
  - No partial `st_cp` pulse is produced.
  - `ready` equals `en` from the first cycle after reset.

## Timing
- Reset values: `sh_cp`=0, `st_cp`=0, `ds`=0. `ready` = `en` once state is IDLE.
- With the accept at edge t:
  - `ds` carries bit k (MSB first) during `clk` cycles t+1+2·`SCLK_DIV`·(`DATA_W`-1-k) … onward.
  - `sh_cp` rises `SCLK_DIV` cycles after each `ds` change, so setup equals hold, which equals `SCLK_DIV` cycles.
- `st_cp` is high for exactly `SCLK_DIV` cycles, starting at cycle t+2·`SCLK_DIV`·`DATA_W`+1.
- `ready` is low for exactly 2·`SCLK_DIV`·`DATA_W` + `SCLK_DIV` cycles. It reasserts at cycle t+2·`SCLK_DIV`·`DATA_W`+`SCLK_DIV`+1.
- Back-to-back: with `valid` held high, the next word is accepted on the first cycle `ready` is high. There is zero gap cycles beyond the IDLE cycle.
- All outputs except `ready` are registered; there are no combinational paths from inputs to pins.

## Configuration
- `HC595_LSB_FIRST_EN` defined: bit 0 is shifted first and `sreg` shifts right.
- Undefined (default): MSB first, shift left.
- Latency and handshake are identical in both modes.

## Structure
- `defines.v` holds the default `` `HC595_SCLK_DIV `` and `` `HC595_DATA_W `` so that the top level and the scan logic agree.
- State encodings are local parameters of this module, not shared.
- No sub-module: the tick counter, bit counter and FSM are inline. The CLK_DIV block is not reused, because `sh_cp` must be phase-locked to the FSM.

## Test plan
- Reset, `en`=1, one word 16'hA5C3 (`DATA_W`=16, `SCLK_DIV`=2):
  - `ds` sampled on the 16 `sh_cp` rising edges = 1010_0101_1100_0011.
  - Exactly one `st_cp` pulse, 2 cycles wide.
  - `ready` low for 66 cycles.
- `valid` held high with words 16'h00FF then 16'hFF00:
  - Both are shifted correctly.
  - The second is accepted the cycle `ready` returns.
  - Two `st_cp` pulses total.
- `en`=0 with `valid`=1: no accept and `sh_cp` stays 0. `en` dropped at cycle 10 of a word: the word completes with `st_cp`, and `ready` stays low afterwards.
- `reset` pulsed at cycle 20 of 16'h1234:
  - Next cycle `sh_cp`=`st_cp`=`ds`=0, with no `st_cp` pulse.
  - The following 16'h8001 shifts cleanly.
- `HC595_LSB_FIRST_EN` defined, word 16'h0001: first `ds` bit = 1, remaining 15 bits = 0.
- `SCLK_DIV`=1, `DATA_W`=16, word 16'hFFFF: `ready` low 33 cycles, 16 `sh_cp` pulses, `st_cp` 1 cycle wide.
